uart_led_ctrl: RTL and testbench
================================

UART_LED_CTRL -- requirements
Module: uart_led_ctrl

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 24'd10_000_000, meaning the blink half-period in clk cycles.
REQ-002 SHALL have port clk  input  1  sole clock; all flops are rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port tx_busy  input  1  UART transmitter busy; high while a frame is in flight.
REQ-007 SHALL have port tx_data  output  8  response byte, held stable from the tx_start cycle until the next response.
REQ-008 SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-009 SHALL have port led_port  output  7  LED drive.
REQ-010 SHALL have port err_ovf  output  1  sticky flag for a received byte that was dropped.

Function
REQ-011 SHALL implement an FSM with states IDLE, ARG_L, ARG_B and RESP.
REQ-012 SHALL define "byte available" as: pending slot full, else rx_valid; the pending slot has priority over rx_valid.
REQ-013 IDLE command decode SHALL be: 0x4C to ARG_L; 0x42 to ARG_B; 0x3F sets resp={1'b0,led_reg} and goes to RESP; any other byte sets resp=0x45 ('E') and goes to RESP.
REQ-014 ARG_L SHALL, on a byte, set led_reg<=byte[6:0] and resp=0x4B ('K'), then go to RESP.
REQ-015 ARG_B SHALL, on a byte, set blink_mask<=byte[6:0] and resp=0x4B, then go to RESP.
REQ-016 RESP SHALL, when tx_busy=0, take the next cycle as tx_start=1 with tx_data=resp and state=IDLE; while tx_busy=1 it SHALL hold.
REQ-017 Latency SHALL be: a byte accepted at cycle N gives state RESP at N+1, and tx_start at N+2 if tx_busy=0 at N+1.
REQ-018 tx_start SHALL never be high for two consecutive cycles.
REQ-019 A byte with rx_valid=1 arriving in RESP SHALL load the pending slot if it is empty; if the slot is full, the byte SHALL be dropped and err_ovf<=1.
REQ-020 When the pending slot is consumed in the same cycle rx_valid=1, the new byte SHALL refill the slot; no drop and no err_ovf.
REQ-021 The blink counter SHALL be 24-bit and count 0..MAX_COUNT-1, then wrap to 0 and toggle blink_phase; it SHALL run freely in every state.
REQ-022 led_port SHALL be the registered value led_reg ^ (blink_phase ? blink_mask : 7'h00).
REQ-023 A led_reg or blink_mask update at cycle N SHALL appear on led_port at N+1.
REQ-024 err_ovf SHALL be cleared only by rst.

Reset
REQ-025 While rst=1, the block SHALL hold: state=IDLE; led_reg=0; blink_mask=0; blink counter=0; blink_phase=0; pending slot empty; tx_start=0; tx_data=0x00; led_port=0; err_ovf=0.
REQ-026 Reset asserted mid-operation (in ARG_x or RESP) SHALL discard the partial command and any pending byte, and SHALL emit no tx_start.
REQ-027 After rst falls, the first rx_valid SHALL be decoded as a command byte.

Configuration
REQ-028 Macro UART_LED_CTRL_TIMEOUT_EN SHALL control the argument timeout.
REQ-029 With the macro defined, a 24-bit timeout counter SHALL clear on entering ARG_L or ARG_B; if MAX_COUNT cycles pass with no byte, resp=0x54 ('T'), state goes to RESP, and led_reg and blink_mask are unchanged.
REQ-030 Without the macro, ARG_L and ARG_B SHALL wait indefinitely, and no timeout logic SHALL exist.

Verification
REQ-031 LED set: rx 0x4C then 0xAA, tx_busy=0 -> led_port=0x2A one cycle after the arg byte; tx_start pulses once with tx_data=0x4B.
REQ-032 Query plus backpressure: led_reg=0x15, rx 0x3F, tx_busy=1 for 20 cycles -> no tx_start during busy; one tx_start with tx_data=0x15 one cycle after busy falls.
REQ-033 Overflow: in RESP with tx_busy=1, send 0x3F, 0x3F, 0x3F -> first byte pending, second dropped, err_ovf=1; after release exactly two tx_start pulses total.
REQ-034 Blink: MAX_COUNT=4, led_reg=0x00, blink_mask=0x7F -> led_port toggles 0x00/0x7F every 4 cycles.
REQ-035 Unknown plus reset: rx 0x00 -> tx_data=0x45; rx 0x4C, then rst mid-ARG_L -> no tx_start, all outputs zero, next 0x3F returns 0x00.
REQ-036 Timeout (macro defined, MAX_COUNT=8): rx 0x42 then idle for 8 cycles -> tx_data=0x54 and blink_mask stays 0; without the macro, no tx_start.

Source files
------------

// File: rtl/uart_led_ctrl.sv
// uart_led_ctrl: byte-command LED controller behind a UART.
// Commands: 'L' <arg> sets the LED register, 'B' <arg> sets the blink mask,
// '?' returns the LED register, and anything else returns 'E'. Each command
// produces one response byte on tx_data/tx_start.
// One received byte can wait in a pending slot while a response is held off
// by tx_busy. A byte that arrives when the slot is already full is dropped and
// sets err_ovf.
// Optional feature: define UART_LED_CTRL_TIMEOUT_EN to abandon an argument
// wait after MAX_COUNT idle cycles. The controller then responds with 'T'.
//
// state | meaning
// IDLE  | waiting for a command byte
// ARG_L | waiting for the LED-register argument
// ARG_B | waiting for the blink-mask argument
// RESP  | response latched, waiting for tx_busy low to send it
module uart_led_ctrl #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [6:0] led_port,
    output logic       err_ovf
);

    typedef enum logic [1:0] {IDLE, ARG_L, ARG_B, RESP} state_t;

    localparam logic [7:0] CMD_LED   = 8'h4C;
    localparam logic [7:0] CMD_BLINK = 8'h42;
    localparam logic [7:0] CMD_QUERY = 8'h3F;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    state_t      state, state_nxt;
    logic [7:0]  resp, resp_nxt;
    logic [6:0]  led_reg, led_nxt;
    logic [6:0]  blink_mask, mask_nxt;
    logic        pend_full;
    logic [7:0]  pend_data;
    logic        avail;
    logic [7:0]  byte_in;
    logic        consume;
    logic        tx_load;
    logic        timeout;
    logic [23:0] blink_cnt;
    logic        blink_phase, phase_nxt;
    logic        blink_wrap;

    // The pending slot always takes priority over a fresh rx_valid byte.
    assign avail   = pend_full | rx_valid;
    assign byte_in = pend_full ? pend_data : rx_data;

`ifdef UART_LED_CTRL_TIMEOUT_EN
    logic [23:0] to_cnt;

    // Count idle cycles spent waiting for an argument. The count is zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= 24'd0;
        else if ((state == ARG_L || state == ARG_B) && !avail)
            to_cnt <= to_cnt + 24'd1;
        else
            to_cnt <= 24'd0;
    end

    assign timeout = (state == ARG_L || state == ARG_B) && !avail &&
                     (to_cnt == MAX_COUNT - 24'd1);
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (avail) begin
                    if (byte_in == CMD_LED)
                        state_nxt = ARG_L;
                    else if (byte_in == CMD_BLINK)
                        state_nxt = ARG_B;
                    else
                        state_nxt = RESP;
                end
            end
            ARG_L, ARG_B: begin
                if (avail || timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                if (!tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state datapath controls: byte consumption, register loads, response select
    always_comb begin
        resp_nxt = resp;
        led_nxt  = led_reg;
        mask_nxt = blink_mask;
        consume  = 1'b0;
        tx_load  = 1'b0;
        case (state)
            IDLE: begin
                if (avail) begin
                    consume = 1'b1;
                    if (byte_in == CMD_QUERY)
                        resp_nxt = {1'b0, led_reg};
                    else if (byte_in != CMD_LED && byte_in != CMD_BLINK)
                        resp_nxt = RSP_ERR;
                end
            end
            ARG_L: begin
                if (avail) begin
                    consume  = 1'b1;
                    led_nxt  = byte_in[6:0];
                    resp_nxt = RSP_OK;
                end else if (timeout) begin
                    resp_nxt = RSP_TMO;
                end
            end
            ARG_B: begin
                if (avail) begin
                    consume  = 1'b1;
                    mask_nxt = byte_in[6:0];
                    resp_nxt = RSP_OK;
                end else if (timeout) begin
                    resp_nxt = RSP_TMO;
                end
            end
            RESP: begin
                tx_load = !tx_busy;
            end
            default: ;
        endcase
    end

    // Command registers and the registered transmit request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp       <= 8'h00;
            led_reg    <= 7'h00;
            blink_mask <= 7'h00;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            resp       <= resp_nxt;
            led_reg    <= led_nxt;
            blink_mask <= mask_nxt;
            tx_start   <= tx_load;
            if (tx_load)
                tx_data <= resp;
        end
    end

    // Pending slot: refilled when it is consumed alongside a new byte.
    // A new byte is dropped (sticky err_ovf) if it arrives unconsumed while the slot is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_data <= 8'h00;
            err_ovf   <= 1'b0;
        end else if (consume && pend_full) begin
            pend_full <= rx_valid;
            pend_data <= rx_data;
        end else if (!consume && rx_valid) begin
            if (!pend_full) begin
                pend_full <= 1'b1;
                pend_data <= rx_data;
            end else begin
                err_ovf <= 1'b1;
            end
        end
    end

    assign blink_wrap = (blink_cnt == MAX_COUNT - 24'd1);
    assign phase_nxt  = blink_wrap ? ~blink_phase : blink_phase;

    // Free-running blink half-period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= 24'd0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= blink_wrap ? 24'd0 : blink_cnt + 24'd1;
            blink_phase <= phase_nxt;
        end
    end

    // LED drive is built from next-cycle values so a register update is visible one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led_port <= 7'h00;
        else
            led_port <= led_nxt ^ (phase_nxt ? mask_nxt : 7'h00);
    end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// tb_uart_led_ctrl: directed bench for uart_led_ctrl.
// Two instances share the stimulus: dut uses MAX_COUNT=8, which is also the
// timeout length, and dut4 uses MAX_COUNT=4 and is observed for blinking.
// The bench honours UART_LED_CTRL_TIMEOUT_EN the same way the design does.
module tb_uart_led_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data, tx_data4;
    logic       tx_start, tx_start4;
    logic [6:0] led_port, led_port4;
    logic       err_ovf, err_ovf4;

    int checks = 0;
    int errors = 0;
    int consec = 0;
    logic prev_start = 1'b0;

    uart_led_ctrl #(.MAX_COUNT(24'd8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
        .led_port(led_port), .err_ovf(err_ovf)
    );

    uart_led_ctrl #(.MAX_COUNT(24'd4)) dut4 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_data(tx_data4), .tx_start(tx_start4),
        .led_port(led_port4), .err_ovf(err_ovf4)
    );

    always #5 clk = ~clk;

    // Flag any back-to-back tx_start pulses
    always @(negedge clk) begin
        if (!rst && tx_start && prev_start)
            consec = consec + 1;
        prev_start = tx_start;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] arg;
        bit         has_arg;
        logic [7:0] exp_tx;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // The byte was accepted in the cycle before the current negedge, so tx_start is due at the next negedge
    task automatic expect_tx(input string name, input logic [7:0] exp);
        @(negedge clk);
        check({name, "_start"}, int'(tx_start), 1);
        check({name, "_data"}, int'(tx_data), int'(exp));
        @(negedge clk);
        check({name, "_single"}, int'(tx_start), 0);
    endtask

    initial begin
        int seen;
        logic [7:0] last;
        logic [6:0] s[24];
        int first;
        int bad;

        vecs[0] = '{8'h4C, 8'hAA, 1'b1, 8'h4B, 8'h2A};
        vecs[1] = '{8'h3F, 8'h00, 1'b0, 8'h2A, 8'h2A};
        vecs[2] = '{8'h42, 8'h00, 1'b1, 8'h4B, 8'h2A};
        vecs[3] = '{8'h4C, 8'h15, 1'b1, 8'h4B, 8'h15};
        vecs[4] = '{8'h3F, 8'h00, 1'b0, 8'h15, 8'h15};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h45, 8'h15};
        vecs[6] = '{8'h7E, 8'h00, 1'b0, 8'h45, 8'h15};
        vecs[7] = '{8'h4B, 8'h00, 1'b0, 8'h45, 8'h15};
        vecs[8] = '{8'h4C, 8'hFF, 1'b1, 8'h4B, 8'h7F};
        vecs[9] = '{8'h4C, 8'h15, 1'b1, 8'h4B, 8'h15};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_led", int'(led_port), 0);
        check("rst_err", int'(err_ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven command/response vectors, tx_busy low
        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].cmd);
            if (vecs[i].has_arg)
                send_byte(vecs[i].arg);
            check($sformatf("vec%0d_led", i), int'(led_port), int'(vecs[i].exp_led));
            expect_tx($sformatf("vec%0d_tx", i), vecs[i].exp_tx);
        end

        // Query held off by tx_busy for 20 cycles
        tx_busy = 1'b1;
        send_byte(8'h3F);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        check("busy_hold", seen, 0);
        tx_busy = 1'b0;
        expect_tx("busy_release", 8'h15);

        // Overflow: the first byte gets a response, the second waits in the pending slot, the third is dropped
        tx_busy = 1'b1;
        send_byte(8'h3F);
        send_byte(8'h3F);
        check("ovf_pending_no_err", int'(err_ovf), 0);
        send_byte(8'h3F);
        check("ovf_dropped_err", int'(err_ovf), 1);
        tx_busy = 1'b0;
        seen = 0;
        last = 8'h00;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) begin
                seen++;
                last = tx_data;
            end
        end
        check("ovf_pulses", seen, 2);
        check("ovf_last_data", int'(last), 8'h15);
        check("ovf_sticky", int'(err_ovf), 1);

        // Blink: led_reg=0, blink_mask=7F on the MAX_COUNT=4 instance
        send_byte(8'h4C);
        send_byte(8'h00);
        expect_tx("blink_set_led", 8'h4B);
        send_byte(8'h42);
        send_byte(8'h7F);
        expect_tx("blink_set_mask", 8'h4B);
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            s[j] = led_port4;
        end
        first = -1;
        for (int j = 1; j < 24; j++)
            if (first < 0 && s[j] != s[j-1]) first = j;
        check("blink_toggle_seen", int'(first >= 1 && first <= 4), 1);
        bad = 0;
        for (int j = 0; j < 24; j++) begin
            if (s[j] != 7'h00 && s[j] != 7'h7F) bad++;
            if (j >= 1 && first >= 1) begin
                if ((s[j] != s[j-1]) != ((j >= first) && ((j - first) % 4 == 0))) bad++;
            end
        end
        check("blink_period", bad, 0);

        // Unknown command, then reset in the middle of ARG_L
        send_byte(8'h00);
        expect_tx("unknown_cmd", 8'h45);
        send_byte(8'h4C);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_tx_start", int'(tx_start), 0);
        check("midrst_tx_data", int'(tx_data), 0);
        check("midrst_led", int'(led_port), 0);
        check("midrst_led4", int'(led_port4), 0);
        check("midrst_err", int'(err_ovf), 0);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        check("midrst_no_tx", seen, 0);
        send_byte(8'h3F);
        expect_tx("post_rst_query", 8'h00);

        // Argument timeout: 'B' followed by silence
        send_byte(8'h42);
        seen = 0;
        last = 8'h00;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) begin
                seen++;
                last = tx_data;
            end
        end
`ifdef UART_LED_CTRL_TIMEOUT_EN
        check("timeout_pulses", seen, 1);
        check("timeout_data", int'(last), 8'h54);
`else
        check("no_timeout_pulses", seen, 0);
`endif
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_port4 != 7'h00) bad++;
        end
        check("timeout_mask_kept", bad, 0);

        check("no_consecutive_start", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
